// File: rtl/control_sequencer.sv
// control_sequencer
//   Moore FSM that sequences the single-bus datapath through fetch (T0-T2),
//   decode (T3), execute (T4 / DIV_WAIT) and writeback (T5 / T6) for
//   register-register ALU ops, MUL/DIV, NEG/NOT, NOP and HALT.
//
// Optional build macro: CTRL_SINGLE_STEP_EN
//   When defined, adds input 'step'. T0 only starts a fetch when run and step
//   are both high in the same cycle. One step pulse executes one instruction.
//
// Ports
//   clk, clr        clock, synchronous active-high reset
//   run             fetch enable, sampled only in T0
//   step            (CTRL_SINGLE_STEP_EN only) single-step qualifier for run
//   mem_rdy         memory read data valid
//   ir              IR register contents: opcode[31:27] ra[26:23] rb[22:19] rc[18:15]
//   div_done        divider result ready
//   reg_in/reg_out  one-hot register load / bus-drive selects
//   alu_op          one-hot {SHRA,NOT,NEG,ROL,ROR,SHL,SHR,DIV,MUL,SUB,ADD,OR,AND}
//   PCout..div_rst  bus drivers, register loads, memory read, PC increment, divider reset
//   halted, err     sticky status flags
//   instr_count     retired-instruction count (wraps)
//   state           current state code
module control_sequencer #(
    parameter int DIV_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             run,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic             step,
`endif
    input  logic             mem_rdy,
    input  logic [31:0]      ir,
    input  logic             div_done,
    output logic [15:0]      reg_in,
    output logic [15:0]      reg_out,
    output logic [12:0]      alu_op,
    output logic             PCout,
    output logic             MDRout,
    output logic             Zhighout,
    output logic             Zlowout,
    output logic             MARin,
    output logic             MDRin,
    output logic             IRin,
    output logic             Yin,
    output logic             Zin,
    output logic             HIin,
    output logic             LOin,
    output logic             Read,
    output logic             IncPC,
    output logic             div_rst,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] instr_count,
    output logic [3:0]       state
);

    localparam int             DCW      = (DIV_TIMEOUT > 2) ? $clog2(DIV_TIMEOUT) : 1;
    localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV_TIMEOUT - 1);

    typedef enum logic [3:0] {
        T0 = 4'd0, T1 = 4'd1, T2 = 4'd2, T3 = 4'd3, T4 = 4'd4,
        DIV_WAIT = 4'd5, T5 = 4'd6, T6 = 4'd7, HALT = 4'd8
    } state_t;

    state_t         state_q, state_d;
    logic [DCW-1:0] div_cnt;
    logic           set_err, set_halt, retire, div_clr, div_inc, go;

    logic [4:0]  opcode;
    logic [3:0]  ra, rb, rc;
    logic        is_alu, is_mul, is_div, is_negnot, is_nop, is_halt;
    logic [12:0] alu_sel;
    logic        unused_ir;

    assign opcode    = ir[31:27];
    assign ra        = ir[26:23];
    assign rb        = ir[22:19];
    assign rc        = ir[18:15];
    assign unused_ir = ^ir[14:0];
    assign state     = state_q;

`ifdef CTRL_SINGLE_STEP_EN
    assign go = run & step;
`else
    assign go = run;
`endif

    function automatic logic [15:0] onehot16(input logic [3:0] idx);
        onehot16 = 16'd1 << idx;
    endfunction

    // Opcode decode; anything not matched is illegal (all class flags low).
    always_comb begin
        is_alu    = 1'b0;
        is_mul    = 1'b0;
        is_div    = 1'b0;
        is_negnot = 1'b0;
        is_nop    = 1'b0;
        is_halt   = 1'b0;
        alu_sel   = 13'd0;
        case (opcode)
            5'b00101: begin is_alu    = 1'b1; alu_sel = 13'h0001; end // and
            5'b00110: begin is_alu    = 1'b1; alu_sel = 13'h0002; end // or
            5'b00011: begin is_alu    = 1'b1; alu_sel = 13'h0004; end // add
            5'b00100: begin is_alu    = 1'b1; alu_sel = 13'h0008; end // sub
            5'b01111: begin is_mul    = 1'b1; alu_sel = 13'h0010; end // mul
            5'b10000: begin is_div    = 1'b1; alu_sel = 13'h0020; end // div
            5'b01001: begin is_alu    = 1'b1; alu_sel = 13'h0040; end // shr
            5'b01011: begin is_alu    = 1'b1; alu_sel = 13'h0080; end // shl
            5'b00111: begin is_alu    = 1'b1; alu_sel = 13'h0100; end // ror
            5'b01000: begin is_alu    = 1'b1; alu_sel = 13'h0200; end // rol
            5'b10001: begin is_negnot = 1'b1; alu_sel = 13'h0400; end // neg
            5'b10010: begin is_negnot = 1'b1; alu_sel = 13'h0800; end // not
            5'b01010: begin is_alu    = 1'b1; alu_sel = 13'h1000; end // shra
            5'b11000: is_nop  = 1'b1;
            5'b11010: is_halt = 1'b1;
            default:  ;
        endcase
    end

    // State register and sticky status; clr overrides every transition.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= T0;
            halted      <= 1'b0;
            err         <= 1'b0;
            instr_count <= '0;
            div_cnt     <= '0;
        end else begin
            state_q <= state_d;
            if (set_err)  err    <= 1'b1;
            if (set_halt) halted <= 1'b1;
            if (retire)   instr_count <= instr_count + CNT_W'(1);
            if (div_clr)
                div_cnt <= '0;
            else if (div_inc)
                div_cnt <= div_cnt + DCW'(1);
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        set_err  = 1'b0;
        set_halt = 1'b0;
        retire   = 1'b0;
        div_clr  = 1'b0;
        div_inc  = 1'b0;
        case (state_q)
            T0: if (go) state_d = T1;
            T1: if (mem_rdy) state_d = T2;
            T2: state_d = T3;
            T3: begin
                if (is_alu || is_mul || is_div) begin
                    state_d = T4;
                end else if (is_negnot) begin
                    state_d = T5;
                end else if (is_nop) begin
                    state_d = T0;
                    retire  = 1'b1;
                end else if (is_halt) begin
                    state_d  = HALT;
                    set_halt = 1'b1;
                    retire   = 1'b1;
                end else begin
                    state_d = T0;
                    set_err = 1'b1;
                end
            end
            T4: begin
                state_d = is_div ? DIV_WAIT : T5;
                div_clr = 1'b1;
            end
            DIV_WAIT: begin
                // div_done wins over the timeout on the final wait cycle.
                if (div_done) begin
                    state_d = T5;
                    div_clr = 1'b1;
                end else if (div_cnt == DIV_LAST) begin
                    state_d = T0;
                    set_err = 1'b1;
                    div_clr = 1'b1;
                end else begin
                    div_inc = 1'b1;
                end
            end
            T5: begin
                if (is_mul || is_div) begin
                    state_d = T6;
                end else begin
                    state_d = T0;
                    retire  = 1'b1;
                end
            end
            T6: begin
                state_d = T0;
                retire  = 1'b1;
            end
            HALT:    state_d = HALT;
            default: state_d = T0;
        endcase
    end

    // Output decode from the state register (T0 additionally gated by go).
    always_comb begin
        reg_in   = 16'd0;
        reg_out  = 16'd0;
        alu_op   = 13'd0;
        PCout    = 1'b0;
        MDRout   = 1'b0;
        Zhighout = 1'b0;
        Zlowout  = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        Read     = 1'b0;
        IncPC    = 1'b0;
        div_rst  = 1'b0;
        case (state_q)
            T0: begin
                PCout = go;
                MARin = go;
                IncPC = go;
            end
            T1: begin
                Read  = 1'b1;
                MDRin = 1'b1;
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            T3: begin
                if (is_alu || is_mul || is_div) begin
                    reg_out = onehot16(rb);
                    Yin     = 1'b1;
                    div_rst = is_div;
                end else if (is_negnot) begin
                    reg_out = onehot16(rb);
                    alu_op  = alu_sel;
                    Zin     = 1'b1;
                end
            end
            T4: begin
                reg_out = onehot16(rc);
                alu_op  = alu_sel;
                Zin     = 1'b1;
            end
            DIV_WAIT: begin
                reg_out = onehot16(rc);
                alu_op  = 13'h0020;
                Zin     = 1'b1;
            end
            T5: begin
                Zlowout = 1'b1;
                if (is_mul || is_div)
                    LOin = 1'b1;
                else
                    reg_in = onehot16(ra);
            end
            T6: begin
                Zhighout = 1'b1;
                HIin     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer: per-instruction reference micro-programs
// are pushed into a scoreboard; a monitor pops and compares whenever the DUT
// asserts any strobe. Status (state, err, halted, instr_count) is checked at
// the model-predicted completion cycle.
module tb_control_sequencer;

    logic        clk = 1'b0;
    logic        clr, run, mem_rdy, div_done;
    logic [31:0] ir;
    logic [15:0] reg_in, reg_out;
    logic [12:0] alu_op;
    logic        PCout, MDRout, Zhighout, Zlowout, MARin, MDRin, IRin, Yin, Zin;
    logic        HIin, LOin, Read, IncPC, div_rst, halted, err;
    logic [31:0] instr_count;
    logic [3:0]  state;
`ifdef CTRL_SINGLE_STEP_EN
    logic        step = 1'b1;
`endif

    always #5 clk = ~clk;

    control_sequencer #(.DIV_TIMEOUT(64), .CNT_W(32)) dut (
        .clk(clk), .clr(clr), .run(run),
`ifdef CTRL_SINGLE_STEP_EN
        .step(step),
`endif
        .mem_rdy(mem_rdy), .ir(ir), .div_done(div_done),
        .reg_in(reg_in), .reg_out(reg_out), .alu_op(alu_op),
        .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout),
        .MARin(MARin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Zin(Zin),
        .HIin(HIin), .LOin(LOin), .Read(Read), .IncPC(IncPC), .div_rst(div_rst),
        .halted(halted), .err(err), .instr_count(instr_count), .state(state)
    );

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [12:0] alu;
        logic [13:0] f;
    } exp_t;

    localparam logic [13:0] M_PCOUT = 14'h0001, M_MDROUT = 14'h0002,
                            M_ZHIGH = 14'h0004, M_ZLOW   = 14'h0008,
                            M_MARIN = 14'h0010, M_MDRIN  = 14'h0020,
                            M_IRIN  = 14'h0040, M_YIN    = 14'h0080,
                            M_ZIN   = 14'h0100, M_HIIN   = 14'h0200,
                            M_LOIN  = 14'h0400, M_READ   = 14'h0800,
                            M_INCPC = 14'h1000, M_DIVRST = 14'h2000;
    localparam logic [12:0] A_DIV = 13'h0020;

    int          checks = 0;
    int          errors = 0;
    exp_t        sb_q[$];
    exp_t        obs, mon_e;
    logic [31:0] exp_count = 32'd0;
    logic        exp_err = 1'b0;
    logic        exp_halt = 1'b0;

    always_comb begin
        obs.st   = state;
        obs.rin  = reg_in;
        obs.rout = reg_out;
        obs.alu  = alu_op;
        obs.f    = {div_rst, IncPC, Read, LOin, HIin, Zin, Yin, IRin, MDRin,
                    MARin, Zlowout, Zhighout, MDRout, PCout};
    end

    // Monitor: every cycle with any strobe active consumes one expectation.
    always @(negedge clk) begin
        if (|{obs.rin, obs.rout, obs.alu, obs.f}) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobes t=%0t got=%h", $time, obs);
            end else begin
                mon_e = sb_q.pop_front();
                if (obs !== mon_e) begin
                    errors++;
                    $display("FAIL strobe_seq t=%0t got=%h exp=%h", $time, obs, mon_e);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", name, $time, got, expv);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] st, input logic [15:0] rin,
                                input logic [15:0] rout, input logic [12:0] alu,
                                input logic [13:0] f);
        exp_t e;
        e.st = st; e.rin = rin; e.rout = rout; e.alu = alu; e.f = f;
        return e;
    endfunction

    function automatic logic [15:0] oh(input logic [3:0] i);
        logic [15:0] one = 16'd1;
        return one << i;
    endfunction

    // 0 alu, 1 mul, 2 div, 3 neg/not, 4 nop, 5 halt, 6 illegal
    function automatic int cls(input logic [4:0] op);
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01001, 5'b01010, 5'b01011: return 0;
            5'b01111: return 1;
            5'b10000: return 2;
            5'b10001, 5'b10010: return 3;
            5'b11000: return 4;
            5'b11010: return 5;
            default:  return 6;
        endcase
    endfunction

    function automatic logic [12:0] alu_of(input logic [4:0] op);
        case (op)
            5'b00101: return 13'h0001; 5'b00110: return 13'h0002;
            5'b00011: return 13'h0004; 5'b00100: return 13'h0008;
            5'b01111: return 13'h0010; 5'b10000: return 13'h0020;
            5'b01001: return 13'h0040; 5'b01011: return 13'h0080;
            5'b00111: return 13'h0100; 5'b01000: return 13'h0200;
            5'b10001: return 13'h0400; 5'b10010: return 13'h0800;
            5'b01010: return 13'h1000;
            default:  return 13'h0000;
        endcase
    endfunction

    function automatic logic [31:0] mkir(input logic [4:0] op, input logic [3:0] a,
                                         input logic [3:0] b, input logic [3:0] c);
        return {op, a, b, c, 15'($urandom)};
    endfunction

    // Run one instruction. w = extra mem_rdy-low cycles in T1; d = DIV_WAIT
    // cycle on which div_done rises (0 = never); clr_at = cycle to assert clr (-1 none).
    task automatic run_instr(input logic [31:0] i, input int w, input int d, input int clr_at);
        exp_t        q[$];
        logic [4:0]  op = i[31:27];
        logic [3:0]  ra = i[26:23];
        logic [3:0]  rb = i[22:19];
        logic [3:0]  rc = i[18:15];
        int          c = cls(op);
        int          len, last, lim;
        bit          abort = 0;
        logic [31:0] cnt_before = exp_count;

        q.push_back(mk(4'd0, 16'd0, 16'd0, 13'd0, M_PCOUT | M_MARIN | M_INCPC));
        for (int n = 0; n <= w; n++) q.push_back(mk(4'd1, 16'd0, 16'd0, 13'd0, M_READ | M_MDRIN));
        q.push_back(mk(4'd2, 16'd0, 16'd0, 13'd0, M_MDROUT | M_IRIN));
        if (c <= 2) begin
            q.push_back(mk(4'd3, 16'd0, oh(rb), 13'd0, M_YIN | ((c == 2) ? M_DIVRST : 14'd0)));
            q.push_back(mk(4'd4, 16'd0, oh(rc), alu_of(op), M_ZIN));
            if (c == 2) begin
                abort = (d == 0);
                for (int n = 0; n < ((d == 0) ? 64 : d); n++)
                    q.push_back(mk(4'd5, 16'd0, oh(rc), A_DIV, M_ZIN));
            end
            if (!abort) begin
                if (c == 0) q.push_back(mk(4'd6, oh(ra), 16'd0, 13'd0, M_ZLOW));
                else begin
                    q.push_back(mk(4'd6, 16'd0, 16'd0, 13'd0, M_ZLOW | M_LOIN));
                    q.push_back(mk(4'd7, 16'd0, 16'd0, 13'd0, M_ZHIGH | M_HIIN));
                end
            end
        end else if (c == 3) begin
            q.push_back(mk(4'd3, 16'd0, oh(rb), alu_of(op), M_ZIN));
            q.push_back(mk(4'd6, oh(ra), 16'd0, 13'd0, M_ZLOW));
        end else begin
            q.push_back(mk(4'd3, 16'd0, 16'd0, 13'd0, 14'd0));
        end
        len  = q.size();
        last = (clr_at >= 0) ? clr_at + 1 : len;
        lim  = (clr_at >= 0) ? clr_at : len - 1;
        for (int k = 0; k <= lim; k++)
            if (|{q[k].rin, q[k].rout, q[k].alu, q[k].f}) sb_q.push_back(q[k]);

        if (clr_at >= 0) begin
            exp_count = 32'd0; exp_err = 1'b0; exp_halt = 1'b0;
        end else begin
            if (c == 6 || abort) exp_err = 1'b1;
            else exp_count = exp_count + 32'd1;
            if (c == 5) exp_halt = 1'b1;
        end

        for (int k = 0; k <= last; k++) begin
            ir       = i;
            run      = (k == 0);
            mem_rdy  = (k >= 1 + w);
            div_done = (d > 0) && (k == 4 + w + d);
            clr      = (k == clr_at);
            if (clr_at < 0 && k == len - 1) chk("count_before_retire", instr_count, cnt_before);
            if (k == last) begin
                chk("end_state", state, (c == 5 && clr_at < 0) ? 4'd8 : 4'd0);
                chk("instr_count", instr_count, exp_count);
                chk("err", err, exp_err);
                chk("halted", halted, exp_halt);
                chk("scoreboard_drained", sb_q.size(), 0);
                if (clr_at >= 0) chk("strobes_after_clr", {obs.rin, obs.rout, obs.alu, obs.f}, 0);
            end else begin
                @(posedge clk); #1;
            end
        end
        run = 1'b0; clr = 1'b0; div_done = 1'b0; mem_rdy = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [4:0] ops[14] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                                5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01111,
                                5'b10000, 5'b10001, 5'b10010, 5'b11000};
        logic [4:0] op;
        int         w, d;

        clr = 1'b1; run = 1'b0; mem_rdy = 1'b0; div_done = 1'b0; ir = 32'd0;
        repeat (3) @(posedge clk);
        #1 clr = 1'b0;
        chk("reset_state", state, 4'd0);
        chk("reset_err", err, 1'b0);
        chk("reset_halted", halted, 1'b0);
        chk("reset_count", instr_count, 32'd0);
        chk("reset_strobes", {obs.rin, obs.rout, obs.alu, obs.f}, 0);

        run_instr(32'h1989_0000, 0, 0, -1);                               // add r3,r1,r2
        run_instr(mkir(5'b01111, 4'd0, 4'd4, 4'd5), 0, 0, -1);            // mul
        run_instr(mkir(5'b10000, 4'd6, 4'd7, 4'd8), 1, 10, -1);           // div, done after 10
        run_instr(mkir(5'b00100, 4'd9, 4'd10, 4'd11), 3, 0, -1);          // sub, mem stall 3
        run_instr(mkir(5'b10001, 4'd15, 4'd14, 4'd0), 0, 0, -1);          // neg
        run_instr(mkir(5'b10010, 4'd1, 4'd2, 4'd3), 2, 0, -1);            // not
        run_instr(mkir(5'b11000, 4'd0, 4'd0, 4'd0), 0, 0, -1);            // nop
        run_instr(mkir(5'b11111, 4'd5, 4'd5, 4'd5), 0, 0, -1);            // illegal
        run_instr(mkir(5'b10000, 4'd2, 4'd3, 4'd4), 0, 0, 10);            // clr in DIV_WAIT
        run_instr(mkir(5'b10000, 4'd2, 4'd3, 4'd4), 0, 0, -1);            // div timeout
        run_instr(mkir(5'b10000, 4'd1, 4'd1, 4'd1), 0, 64, -1);           // done on last wait cycle

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                do op = 5'($urandom); while (cls(op) != 6);
            end else begin
                op = ops[$urandom_range(0, 13)];
            end
            w = $urandom_range(0, 3);
            d = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 20);
            run_instr(mkir(op, 4'($urandom), 4'($urandom), 4'($urandom)), w, d, -1);
        end

        run_instr(mkir(5'b11010, 4'd0, 4'd0, 4'd0), 1, 0, -1);            // halt
        run = 1'b1;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk); #1;
            chk("halt_sticky_state", state, 4'd8);
        end
        run = 1'b0; clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        exp_count = 32'd0; exp_err = 1'b0; exp_halt = 1'b0;
        chk("clr_from_halt_state", state, 4'd0);
        chk("clr_from_halt_halted", halted, exp_halt);
        chk("clr_from_halt_count", instr_count, exp_count);
        run_instr(32'h1989_0000, 0, 0, -1);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
